// File: rtl/regmap_access_arbiter.sv
// rtl/regmap_access_arbiter.sv - round-robin arbiter sharing the register_map port between two requesters
// Optional macro REGMAP_ARB_WPROT_EN blocks writes to the status region and reports them on reqN_err_o.
module regmap_access_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 96,
  parameter int READ_LATENCY   = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_n,
  input  logic                  req0_valid_i,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  req0_ready_o,
  output logic                  req0_rvalid_o,
  output logic [DATA_WIDTH-1:0] req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  req1_ready_o,
  output logic                  req1_rvalid_o,
  output logic [DATA_WIDTH-1:0] req1_rdata_o,
  output logic                  req1_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic       lat_we;
  logic [2:0] wait_cnt;
  logic       grant_any;
  logic       grant_idx;
  logic       capture;
  logic       wr_blocked;

`ifdef REGMAP_ARB_WPROT_EN
  assign wr_blocked = lat_we && (32'(mem_addr_o) >= 32'(NUM_CONFIG_REG));
`else
  assign wr_blocked = 1'b0;
`endif

  // Arbitration is only open in IDLE; a tie goes to whoever did not win last time.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (state == IDLE && rstn_n) begin
      if (req0_valid_i && req1_valid_i) begin
        grant_any = 1'b1;
        grant_idx = ~last_grant;
      end else if (req0_valid_i) begin
        grant_any = 1'b1;
      end else if (req1_valid_i) begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
    end
  end

  assign req0_ready_o = grant_any && !grant_idx;
  assign req1_ready_o = grant_any && grant_idx;
  assign busy_o       = (state != IDLE);

  always_comb begin
    state_next     = state;
    mem_write_en_o = 1'b0;
    mem_read_en_o  = 1'b0;
    capture        = 1'b0;
    req0_rvalid_o  = 1'b0;
    req1_rvalid_o  = 1'b0;
    req0_err_o     = 1'b0;
    req1_err_o     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_next = ISSUE;
      end
      ISSUE: begin
        if (lat_we) begin
          mem_write_en_o = !wr_blocked;
          req0_err_o     = wr_blocked && !owner_o;
          req1_err_o     = wr_blocked && owner_o;
          state_next     = IDLE;
        end else begin
          mem_read_en_o = 1'b1;
          if (READ_LATENCY == 0) begin
            capture    = 1'b1;
            state_next = RESP;
          end else begin
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (4'(wait_cnt) + 4'd1 == 4'(READ_LATENCY)) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        req0_rvalid_o = !owner_o;
        req1_rvalid_o = owner_o;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Captured read data lands straight in the owner's rdata register so it is valid alongside rvalid.
  always_ff @(posedge clk_i) begin
    if (!rstn_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      owner_o          <= 1'b0;
      lat_we           <= 1'b0;
      mem_addr_o       <= '0;
      mem_write_data_o <= '0;
      wait_cnt         <= 3'd0;
      req0_rdata_o     <= '0;
      req1_rdata_o     <= '0;
    end else begin
      state <= state_next;
      if (grant_any) begin
        owner_o          <= grant_idx;
        lat_we           <= grant_idx ? req1_we_i : req0_we_i;
        mem_addr_o       <= grant_idx ? req1_addr_i : req0_addr_i;
        mem_write_data_o <= grant_idx ? req1_wdata_i : req0_wdata_i;
      end
      if (state == ISSUE) wait_cnt <= 3'd0;
      else if (state == RD_WAIT) wait_cnt <= wait_cnt + 3'd1;
      if ((state == ISSUE && lat_we) || state == RESP) last_grant <= owner_o;
      if (capture) begin
        if (owner_o) req1_rdata_o <= mem_read_data_i;
        else req0_rdata_o <= mem_read_data_i;
      end
    end
  end

endmodule

// File: doc/regmap_access_arbiter.md
Name: regmap_access_arbiter

Overview:
- Shares the single register_map access port (addr/write_data/write_en/read_en/read_data) between two requesters: port 0 is the SPI slave memory interface, port 1 is an on-chip host or sequencer.
- Sequences each access as accept, then issue, then optional read wait, then response. Arbitration is fair round-robin.
- Sits between the requesters and register_map, in the clk_i domain.

Parameters:
- ADDR_WIDTH, 7, register address width
- DATA_WIDTH, 8, register data width
- NUM_CONFIG_REG, 96, number of config registers; addresses >= this are the status region
- READ_LATENCY, 1, cycles from the mem_read_en_o cycle to valid mem_read_data_i; legal range 0..7

Ports:
- clk_i  in  1  clock
- rstn_n  in  1  reset, synchronous, active-low
- reqN_valid_i  in  1  request valid (N = 0, 1; all reqN ports are duplicated per requester)
- reqN_we_i  in  1  1 = write, 0 = read
- reqN_addr_i  in  ADDR_WIDTH  register address
- reqN_wdata_i  in  DATA_WIDTH  write data
- reqN_ready_o  out  1  one-cycle accept pulse
- reqN_rvalid_o  out  1  one-cycle read-data-valid pulse
- reqN_rdata_o  out  DATA_WIDTH  read data, held until the next read response on that port
- reqN_err_o  out  1  one-cycle error pulse (optional feature only; tied 0 otherwise)
- mem_addr_o  out  ADDR_WIDTH  to register_map
- mem_write_data_o  out  DATA_WIDTH  to register_map
- mem_write_en_o  out  1  one-cycle write strobe
- mem_read_en_o  out  1  one-cycle read strobe
- mem_read_data_i  in  DATA_WIDTH  from register_map
- busy_o  out  1  high in every state except IDLE
- owner_o  out  1  index of the current or last granted requester

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = 1, so req0 wins the first tie. Reset applies in any state; an in-flight access is abandoned with no ready, rvalid or err pulse.
- Requester protocol:
  - Hold valid high with fields stable until ready pulses.
  - ready pulses exactly once per accepted request.
  - A valid that drops before ready is simply never accepted.
- IDLE:
  - Sampled only in IDLE. If exactly one valid is high, grant it. If both are high, grant the requester not equal to last_grant.
  - In that same cycle: latch we, addr and wdata; pulse the winner's ready_o; set owner_o; go to ISSUE.
  - With no valid, stay in IDLE; mem_* outputs hold their last value and strobes are 0.
- ISSUE (1 cycle):
  - mem_addr_o and mem_write_data_o come from the latch.
  - Write: mem_write_en_o = 1, last_grant = owner, next state IDLE.
  - Read: mem_read_en_o = 1, wait counter cleared to 0. If READ_LATENCY = 0, capture mem_read_data_i this cycle and go to RESP; otherwise go to RD_WAIT.
- RD_WAIT:
  - Counter increments each cycle.
  - In the cycle where counter + 1 == READ_LATENCY, capture mem_read_data_i and go to RESP.
  - mem_addr_o stays stable throughout.
- RESP (1 cycle):
  - Owner's rdata_o is updated with the captured data and its rvalid_o pulses.
  - last_grant = owner; next state IDLE.
  - The non-owner's rdata_o is untouched.
- Throughput:
  - Write: 2 cycles from accept to the next possible accept.
  - Read: 3 + READ_LATENCY cycles. rvalid arrives 2 + READ_LATENCY cycles after ready.
- Back-to-back: a requester holding valid during its own response is re-arbitrated in the next IDLE. If the other requester is also waiting, the other one wins.
- Strobes never overlap; at most one mem strobe is high in any cycle.

Optional Feature:
- Macro: REGMAP_ARB_WPROT_EN
- With the macro defined:
  - A write whose latched addr >= NUM_CONFIG_REG is blocked in ISSUE: mem_write_en_o stays 0 and the owner's err_o pulses in the ISSUE cycle.
  - Reads of the status region are unaffected.
  - Timing is otherwise identical.
- Without the macro: writes pass through unchecked, and err_o is tied to 0.

Test Plan:
- Single write: req0 writes addr 0x05, data 0xA5. Required: ready0 in cycle T; mem_write_en_o = 1 with addr 0x05 and data 0xA5 in T+1; busy_o = 0 in T+2.
- Read, READ_LATENCY = 1: req1 reads 0x05 with the model returning 0xA5. Required: mem_read_en_o at T+1, rvalid1 at T+3 with rdata1 = 0xA5, rvalid0 stays 0.
- Contention: req0 and req1 both valid after reset, both writing different data to 0x10, each re-asserting repeatedly. Required: grant order 0,1,0,1; final register holds the last granted data; no strobe overlap.
- READ_LATENCY = 0 and 3 builds: read addr 0x60 with status input 0x3C. Required: rdata = 0x3C, rvalid at T+2 and T+5 respectively.
- Reset mid-read: rstn_n = 0 in the RD_WAIT cycle. Required: next cycle state IDLE, all outputs 0, no rvalid; a subsequent req0 read completes normally.
- REGMAP_ARB_WPROT_EN: req0 writes 0x70, data 0xFF. Required: err0 pulse at T+1, mem_write_en_o stays 0. A write to 0x5F (95) is strobed normally. Without the macro, the 0x70 write is strobed.
